// File: rtl/ldm_stm_sequencer.sv
// Multi-register transfer sequencer for LDM/STM/PUSH/POP: one word access per
// cycle, load writeback one cycle behind the read, base/SP update on completion.
module ldm_stm_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  opCode,
    input  logic        extra_bit,
    input  logic [7:0]  reg_list,
    input  logic [2:0]  rn,
    input  logic [31:0] base_addr,
    output logic [31:0] mem_addr,
    output logic        mem_write_en,
    output logic [6:0]  mem_op,
    output logic [3:0]  reg_idx,
    output logic [3:0]  wr_idx,
    output logic        reg_write_en,
    output logic        wb_en,
    output logic [31:0] wb_value,
    output logic        stall,
    output logic        done
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]  r_state;
    logic [15:0] r_list;
    logic        r_is_load;
    logic        r_wb_ok;
    logic [31:0] r_wb_calc;
    logic [31:0] r_mem_addr;
    logic        r_mem_we;
    logic [6:0]  r_mem_op;
    logic [3:0]  r_reg_idx;
    logic [3:0]  r_wr_idx;
    logic        r_reg_we;
    logic        r_wb_en;
    logic [31:0] r_wb_value;
    logic        r_done;

    function automatic logic [3:0] f_lowest(input logic [15:0] list);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (list[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] f_popcount(input logic [15:0] list);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {3'd0, list[i]};
        end
        return cnt;
    endfunction

    logic        w_is_stm, w_is_ldm, w_is_push, w_is_pop, w_valid, w_is_load;
    logic [15:0] w_list, w_first_rest, w_next_rest;
    logic [3:0]  w_cnt, w_first_idx, w_next_idx;
    logic [31:0] w_span, w_start_addr, w_wb_calc;
    logic        w_wb_ok, w_accept;

    assign w_is_stm  = (opCode[6:2] == 5'b11000);
    assign w_is_ldm  = (opCode[6:2] == 5'b11001);
    assign w_is_push = (opCode == 7'b1011010);
    assign w_is_pop  = (opCode == 7'b1011110);
    assign w_valid   = w_is_stm | w_is_ldm | w_is_push | w_is_pop;
    assign w_is_load = w_is_ldm | w_is_pop;

    // PUSH adds LR, POP adds PC; both live above the low-register mask
    assign w_list       = {w_is_pop & extra_bit, w_is_push & extra_bit, 6'd0, reg_list};
    assign w_cnt        = f_popcount(w_list);
    assign w_span       = {26'd0, w_cnt, 2'b00};
    assign w_start_addr = w_is_push ? (base_addr - w_span) : base_addr;
    assign w_wb_calc    = w_is_push ? (base_addr - w_span) : (base_addr + w_span);
    assign w_wb_ok      = (w_cnt != 4'd0) & ~(w_is_ldm & reg_list[rn]);
    assign w_accept     = (r_state == ST_IDLE) & start & w_valid;

    assign w_first_idx  = f_lowest(w_list);
    assign w_first_rest = w_list & ~(16'h0001 << w_first_idx);
    assign w_next_idx   = f_lowest(r_list);
    assign w_next_rest  = r_list & ~(16'h0001 << w_next_idx);

    assign stall        = ~rst & (w_accept | (r_state == ST_XFER) | (r_state == ST_DRAIN));
    assign mem_addr     = r_mem_addr;
    assign mem_write_en = r_mem_we;
    assign mem_op       = r_mem_op;
    assign reg_idx      = r_reg_idx;
    assign wr_idx       = r_wr_idx;
    assign reg_write_en = r_reg_we;
    assign wb_en        = r_wb_en;
    assign wb_value     = r_wb_value;
    assign done         = r_done;

    // Sequencer state and registered outputs; strobes default low every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_list     <= 16'd0;
            r_is_load  <= 1'b0;
            r_wb_ok    <= 1'b0;
            r_wb_calc  <= 32'd0;
            r_mem_addr <= 32'd0;
            r_mem_we   <= 1'b0;
            r_mem_op   <= 7'd0;
            r_reg_idx  <= 4'd0;
            r_wr_idx   <= 4'd0;
            r_reg_we   <= 1'b0;
            r_wb_en    <= 1'b0;
            r_wb_value <= 32'd0;
            r_done     <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            r_reg_we <= 1'b0;
            r_wb_en  <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_mem_op  <= opCode;
                        r_is_load <= w_is_load;
                        r_wb_ok   <= w_wb_ok;
                        r_wb_calc <= w_wb_calc;
                        if (w_cnt != 4'd0) begin
                            r_state    <= ST_XFER;
                            r_mem_addr <= w_start_addr;
                            r_mem_we   <= ~w_is_load;
                            r_reg_idx  <= w_first_idx;
                            r_list     <= w_first_rest;
                        end else begin
                            r_state <= ST_DONE;
                            r_list  <= 16'd0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    // load data for the access just issued arrives next cycle
                    r_reg_we <= r_is_load;
                    r_wr_idx <= r_reg_idx;
                    if (r_list != 16'd0) begin
                        r_mem_addr <= r_mem_addr + 32'd4;
                        r_mem_we   <= ~r_is_load;
                        r_reg_idx  <= w_next_idx;
                        r_list     <= w_next_rest;
                    end else if (r_is_load) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_wb_en    <= r_wb_ok;
                        r_wb_value <= r_wb_calc;
                    end
                end
                ST_DRAIN: begin
                    r_state    <= ST_DONE;
                    r_done     <= 1'b1;
                    r_wb_en    <= r_wb_ok;
                    r_wb_value <= r_wb_calc;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Randomized self-checking bench: a per-transaction cycle schedule built from the
// transfer rules is compared against the DUT every negative clock edge.
module tb_ldm_stm_sequencer;
    logic        clk = 1'b0;
    logic        rst, start, extra_bit;
    logic [6:0]  opCode;
    logic [7:0]  reg_list;
    logic [2:0]  rn;
    logic [31:0] base_addr;
    logic [31:0] mem_addr, wb_value;
    logic        mem_write_en, reg_write_en, wb_en, stall, done;
    logic [6:0]  mem_op;
    logic [3:0]  reg_idx, wr_idx;

    ldm_stm_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .opCode(opCode), .extra_bit(extra_bit),
        .reg_list(reg_list), .rn(rn), .base_addr(base_addr), .mem_addr(mem_addr),
        .mem_write_en(mem_write_en), .mem_op(mem_op), .reg_idx(reg_idx), .wr_idx(wr_idx),
        .reg_write_en(reg_write_en), .wb_en(wb_en), .wb_value(wb_value), .stall(stall),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  ridx;
        logic        rwe;
        logic [3:0]  widx;
        logic        wb;
        logic [31:0] wbv;
        logic        dn;
        logic        stl;
        logic [6:0]  op;
        logic        full;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [31:0] m_addr;
    logic [6:0]  m_op;
    logic        chk_en;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    function automatic exp_t quiet_rec();
        exp_t r;
        r.we = 1'b0; r.addr = m_addr; r.ridx = 4'd0; r.rwe = 1'b0; r.widx = 4'd0;
        r.wb = 1'b0; r.wbv = 32'd0; r.dn = 1'b0; r.stl = 1'b0; r.op = m_op; r.full = 1'b0;
        return r;
    endfunction

    function automatic logic op_valid(input logic [6:0] op);
        return (op ==? 7'b11000??) || (op ==? 7'b11001??) || (op == 7'b1011010) || (op == 7'b1011110);
    endfunction

    // Schedule every cycle after the accepted start, straight from the timing rules
    task automatic build(input logic [6:0] op, input logic eb, input logic [7:0] rl,
                         input logic [2:0] r, input logic [31:0] base);
        logic        is_ldm, is_pop, is_push, is_load, wbok;
        logic [15:0] lst;
        int          regs[$];
        int          n;
        logic [31:0] a0, wbv, last;
        exp_t        e;
        is_ldm  = (op ==? 7'b11001??);
        is_pop  = (op == 7'b1011110);
        is_push = (op == 7'b1011010);
        is_load = is_ldm || is_pop;
        lst = {8'd0, rl};
        if (is_push && eb) lst[14] = 1'b1;
        if (is_pop && eb)  lst[15] = 1'b1;
        for (int i = 0; i < 16; i++) if (lst[i]) regs.push_back(i);
        n    = regs.size();
        a0   = is_push ? base - 32'(4 * n) : base;
        wbv  = is_push ? base - 32'(4 * n) : base + 32'(4 * n);
        wbok = (n > 0) && !(is_ldm && rl[r]);
        last = (n > 0) ? a0 + 32'(4 * (n - 1)) : m_addr;
        for (int k = 0; k < n; k++) begin
            e = quiet_rec();
            e.op = op; e.stl = 1'b1; e.addr = a0 + 32'(4 * k);
            e.we = !is_load; e.ridx = 4'(regs[k]);
            e.rwe = is_load && (k > 0); e.widx = (k > 0) ? 4'(regs[k - 1]) : 4'd0;
            exp_q.push_back(e);
        end
        if (is_load && n > 0) begin
            e = quiet_rec();
            e.op = op; e.stl = 1'b1; e.addr = last; e.rwe = 1'b1; e.widx = 4'(regs[n - 1]);
            exp_q.push_back(e);
        end
        e = quiet_rec();
        e.op = op; e.addr = last; e.dn = 1'b1; e.wb = wbok; e.wbv = wbv;
        exp_q.push_back(e);
        m_addr = last;
        m_op   = op;
    endtask

    task automatic drive(input logic s, input logic [6:0] op, input logic eb, input logic [7:0] rl,
                         input logic [2:0] r, input logic [31:0] base, input logic rs);
        @(posedge clk);
        #1;
        rst = rs; start = s; opCode = op; extra_bit = eb; reg_list = rl; rn = r; base_addr = base;
        if (rs) begin
            exp_q.delete();
            m_addr = 32'd0;
            m_op   = 7'd0;
            cur = quiet_rec();
            cur.full = 1'b1;
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else begin
            cur = quiet_rec();
            if (s && op_valid(op)) begin
                cur.stl = 1'b1;
                build(op, eb, rl, r, base);
            end
        end
        chk_en = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 7'd0, 1'b0, 8'd0, 3'd0, 32'd0, 1'b0);
    endtask

    // Single compare point, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(cur.stl));
            chk("mem_write_en", 32'(mem_write_en), 32'(cur.we));
            chk("mem_addr", mem_addr, cur.addr);
            chk("reg_write_en", 32'(reg_write_en), 32'(cur.rwe));
            chk("wb_en", 32'(wb_en), 32'(cur.wb));
            chk("done", 32'(done), 32'(cur.dn));
            chk("mem_op", 32'(mem_op), 32'(cur.op));
            if (cur.we || cur.full)  chk("reg_idx", 32'(reg_idx), 32'(cur.ridx));
            if (cur.rwe || cur.full) chk("wr_idx", 32'(wr_idx), 32'(cur.widx));
            if (cur.wb || cur.full)  chk("wb_value", wb_value, cur.wbv);
        end
    end

    initial begin
        logic [6:0] rop;
        logic       rrs, rs_s;
        rst = 1'b1; start = 1'b0; opCode = 7'd0; extra_bit = 1'b0; reg_list = 8'd0;
        rn = 3'd0; base_addr = 32'd0; chk_en = 1'b0; m_addr = 32'd0; m_op = 7'd0;
        repeat (3) drive(1'b0, 7'd0, 1'b0, 8'd0, 3'd0, 32'd0, 1'b1);
        idle(2);

        // STM list 0x0A at 0x100, with an extra start while busy
        drive(1'b1, 7'b1100000, 1'b0, 8'h0A, 3'd0, 32'h100, 1'b0);
        chk("pin_stm_len", 32'(exp_q.size()), 32'd3);
        chk("pin_stm_a0", exp_q[0].addr, 32'h100);
        chk("pin_stm_i0", 32'(exp_q[0].ridx), 32'd1);
        chk("pin_stm_a1", exp_q[1].addr, 32'h104);
        chk("pin_stm_i1", 32'(exp_q[1].ridx), 32'd3);
        chk("pin_stm_wb", exp_q[2].wbv, 32'h108);
        drive(1'b1, 7'b1100100, 1'b0, 8'hFF, 3'd0, 32'h999, 1'b0);
        idle(3);

        // PUSH {r0,r4,lr} from SP 0x200
        drive(1'b1, 7'b1011010, 1'b1, 8'h11, 3'd0, 32'h200, 1'b0);
        chk("pin_push_len", 32'(exp_q.size()), 32'd4);
        chk("pin_push_a0", exp_q[0].addr, 32'h1F4);
        chk("pin_push_a2", exp_q[2].addr, 32'h1FC);
        chk("pin_push_i2", 32'(exp_q[2].ridx), 32'd14);
        chk("pin_push_wb", exp_q[3].wbv, 32'h1F4);
        idle(5);

        // POP {r2,pc} from SP 0x1F0
        drive(1'b1, 7'b1011110, 1'b1, 8'h04, 3'd0, 32'h1F0, 1'b0);
        chk("pin_pop_a1", exp_q[1].addr, 32'h1F4);
        chk("pin_pop_w1", 32'(exp_q[1].widx), 32'd2);
        chk("pin_pop_w2", 32'(exp_q[2].widx), 32'd15);
        chk("pin_pop_done", 32'(exp_q[3].dn), 32'd1);
        chk("pin_pop_wb", exp_q[3].wbv, 32'h1F8);
        idle(5);

        // LDM r2!, {r1,r2}: base in list, no writeback
        drive(1'b1, 7'b1100100, 1'b0, 8'h06, 3'd2, 32'h80, 1'b0);
        chk("pin_ldm_len", 32'(exp_q.size()), 32'd4);
        chk("pin_ldm_wb", 32'(exp_q[3].wb), 32'd0);
        idle(5);

        // Empty STM, then a start during its DONE cycle
        drive(1'b1, 7'b1100001, 1'b0, 8'h00, 3'd0, 32'h40, 1'b0);
        chk("pin_empty_len", 32'(exp_q.size()), 32'd1);
        drive(1'b1, 7'b1100000, 1'b0, 8'h01, 3'd0, 32'h50, 1'b0);
        idle(3);

        // LDM all eight, reset in cycle 3, restart on release
        drive(1'b1, 7'b1100111, 1'b0, 8'hFF, 3'd0, 32'h300, 1'b0);
        idle(2);
        repeat (2) drive(1'b0, 7'd0, 1'b0, 8'd0, 3'd0, 32'd0, 1'b1);
        drive(1'b1, 7'b1100000, 1'b0, 8'h03, 3'd0, 32'h40, 1'b0);
        chk("pin_restart_len", 32'(exp_q.size()), 32'd3);
        idle(5);

        for (int c = 0; c < 4000; c++) begin
            case ($urandom_range(0, 5))
                0:       rop = {5'b11000, 2'($urandom_range(0, 3))};
                1:       rop = {5'b11001, 2'($urandom_range(0, 3))};
                2:       rop = 7'b1011010;
                3:       rop = 7'b1011110;
                4:       rop = 7'($urandom);
                default: rop = {5'b11001, 2'($urandom_range(0, 3))};
            endcase
            rrs  = ($urandom_range(0, 249) == 0);
            rs_s = rrs ? 1'b0 : 1'($urandom_range(0, 1));
            drive(rs_s, rop, 1'($urandom),
                  ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom),
                  3'($urandom), $urandom, rrs);
        end
        idle(12);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
